// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: round-robin arbiter feeding one uart TX; defining UART_ARB_LOCK_EN adds a lock input for back-to-back re-grants
module uart_tx_arbiter #(
    parameter int N_REQ = 4,
    parameter int GAP_CYCLES = 1,
    parameter int START_TIMEOUT = 4,
    localparam int W = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
    input  logic               txclk,
    input  logic               reset,
    input  logic [N_REQ-1:0]   req,
    input  logic [8*N_REQ-1:0] req_data,
`ifdef UART_ARB_LOCK_EN
    input  logic [N_REQ-1:0]   lock,
`endif
    output logic [N_REQ-1:0]   ack,
    output logic [W-1:0]       grant_id,
    output logic               busy,
    output logic               err,
    output logic               ld_tx_data,
    output logic [7:0]         tx_data,
    output logic               tx_enable,
    input  logic               tx_empty
);
    typedef enum logic [2:0] {IDLE, LOAD, WAIT_START, SEND, GAP} state_t;
    state_t state, state_n;
    logic [W-1:0] ptr, ptr_n, grant_n, win, pick;
    logic [15:0] cnt, cnt_n;
    logic [N_REQ-1:0] ack_n;
    logic [7:0] data_n;
    logic [7:0] bytes [N_REQ];
    logic found, load, relock, ld_n, err_n, en_n;
    for (genvar g = 0; g < N_REQ; g++) begin : g_bytes
        assign bytes[g] = req_data[8*g +: 8];
    end
`ifdef UART_ARB_LOCK_EN
    assign relock = lock[grant_id] && req[grant_id];
`else
    assign relock = 1'b0;
`endif
    // first pending requester after ptr, wrapping
    always_comb begin
        win = ptr;
        found = 1'b0;
        for (int i = 1; i <= N_REQ; i++)
            if (!found && req[W'((int'(ptr) + i) % N_REQ)]) begin
                win = W'((int'(ptr) + i) % N_REQ);
                found = 1'b1;
            end
    end
    always_comb begin
        state_n = state;
        cnt_n = cnt;
        ptr_n = ptr;
        grant_n = grant_id;
        data_n = tx_data;
        ack_n = '0;
        ld_n = 1'b0;
        err_n = 1'b0;
        en_n = tx_enable;
        load = 1'b0;
        pick = grant_id;
        case (state)
            IDLE: if (found && tx_empty) begin
                load = 1'b1;
                pick = win;
            end
            LOAD: begin
                state_n = WAIT_START;
                en_n = 1'b1;
                ptr_n = grant_id;
                cnt_n = '0;
            end
            WAIT_START: if (!tx_empty) state_n = SEND;
                else if (cnt == 16'(START_TIMEOUT - 1)) begin
                    state_n = IDLE;
                    en_n = 1'b0;
                    err_n = 1'b1;
                end else cnt_n = cnt + 16'd1;
            SEND: if (tx_empty) begin
                en_n = 1'b0;
                cnt_n = '0;
                if (GAP_CYCLES != 0) state_n = GAP;
                else if (relock) load = 1'b1;
                else state_n = IDLE;
            end
            GAP: if (cnt == 16'(GAP_CYCLES - 1)) begin
                if (relock) load = 1'b1;
                else state_n = IDLE;
            end else cnt_n = cnt + 16'd1;
            default: state_n = IDLE;
        endcase
        if (load) begin
            state_n = LOAD;
            grant_n = pick;
            data_n = bytes[pick];
            ack_n[pick] = 1'b1;
            ld_n = 1'b1;
        end
    end
    always_ff @(posedge txclk) begin
        if (reset) begin
            state <= IDLE;
            cnt <= '0;
            ptr <= W'(N_REQ - 1);
            grant_id <= '0;
            tx_data <= '0;
            ack <= '0;
            ld_tx_data <= 1'b0;
            err <= 1'b0;
            tx_enable <= 1'b0;
            busy <= 1'b0;
        end else begin
            state <= state_n;
            cnt <= cnt_n;
            ptr <= ptr_n;
            grant_id <= grant_n;
            tx_data <= data_n;
            ack <= ack_n;
            ld_tx_data <= ld_n;
            err <= err_n;
            tx_enable <= en_n;
            busy <= state_n != IDLE;
        end
    end
endmodule

// File: tb/tb_uart_tx_arbiter.sv
// tb_uart_tx_arbiter: scoreboard bench for uart_tx_arbiter with a behavioural uart TX model
module tb_uart_tx_arbiter;
    localparam int N = 4;
    logic txclk = 1'b0;
    logic reset = 1'b1;
    logic [N-1:0] req = '0;
    logic [8*N-1:0] req_data = '0;
    logic [N-1:0] ack;
    logic [1:0] grant_id;
    logic busy, err, ld_tx_data, tx_enable, tx_empty;
    logic [7:0] tx_data;
`ifdef UART_ARB_LOCK_EN
    logic [N-1:0] lock = '0;
`endif
    logic stuck_full = 1'b0;
    logic stuck_empty = 1'b0;
    logic [7:0] u_reg;
    logic [3:0] u_cnt;
    logic [9:0] u_frame;
    logic u_empty, u_done, tx_out, nb;
    logic [7:0] mem [N][16];
    int head [N];
    int tail [N];
    int exp_id [$];
    logic [7:0] exp_dat [$];
    logic [7:0] exp_fr [$];
    logic [N-1:0] last_ack;
    int checks = 0;
    int errors = 0;
    int err_seen = 0;

    uart_tx_arbiter dut (
        .txclk(txclk), .reset(reset), .req(req), .req_data(req_data),
`ifdef UART_ARB_LOCK_EN
        .lock(lock),
`endif
        .ack(ack), .grant_id(grant_id), .busy(busy), .err(err),
        .ld_tx_data(ld_tx_data), .tx_data(tx_data), .tx_enable(tx_enable), .tx_empty(tx_empty)
    );

    always #5 txclk = ~txclk;

    assign tx_empty = stuck_full ? 1'b0 : stuck_empty ? 1'b1 : u_empty;
    always_comb nb = (u_cnt == 4'd0) ? 1'b0 : (u_cnt < 4'd9) ? u_reg[3'(u_cnt - 4'd1)] : 1'b1;
    always @(posedge txclk) begin
        u_done <= 1'b0;
        if (reset) begin
            u_empty <= 1'b1;
            u_cnt <= '0;
            u_reg <= '0;
            u_frame <= '0;
            tx_out <= 1'b1;
        end else begin
            if (ld_tx_data && u_empty && !stuck_empty) begin
                u_reg <= tx_data;
                u_empty <= 1'b0;
            end
            if (tx_enable && !u_empty) begin
                tx_out <= nb;
                u_frame <= {nb, u_frame[9:1]};
                u_cnt <= (u_cnt == 4'd9) ? 4'd0 : u_cnt + 4'd1;
                if (u_cnt == 4'd9) begin
                    u_empty <= 1'b1;
                    u_done <= 1'b1;
                end
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, want);
        end
    endtask

    function automatic void drive_req();
        for (int i = 0; i < N; i++) begin
            req[i] = head[i] < tail[i];
            req_data[8*i +: 8] = mem[i][head[i] % 16];
        end
    endfunction

    task automatic add(input int r, input logic [7:0] b);
        mem[r][tail[r]] = b;
        tail[r]++;
        drive_req();
    endtask

    task automatic expect_grant(input int id, input logic [7:0] b, input bit framed);
        exp_id.push_back(id);
        exp_dat.push_back(b);
        if (framed) exp_fr.push_back(b);
    endtask

    task automatic step();
        int id;
        logic [7:0] d;
        @(negedge txclk);
        last_ack = ack;
        if (err) err_seen++;
        if (ack != '0) begin
            if (exp_id.size() == 0) chk("ack_unexpected", 32'(ack), 0);
            else begin
                id = exp_id.pop_front();
                d = exp_dat.pop_front();
                chk("ack", 32'(ack), 32'(1) << id);
                chk("grant_id", 32'(grant_id), id);
                chk("tx_data", 32'(tx_data), 32'(d));
                chk("ld_tx_data", 32'(ld_tx_data), 1);
            end
            for (int i = 0; i < N; i++) if (ack[i] && head[i] < tail[i]) head[i]++;
            drive_req();
        end
        if (u_done) begin
            if (exp_fr.size() == 0) chk("frame_unexpected", 32'(u_frame), 0);
            else begin
                d = exp_fr.pop_front();
                chk("frame", 32'(u_frame), 32'({1'b1, d, 1'b0}));
            end
        end
    endtask

    task automatic wait_idle(input int budget);
        int n = 0;
        do begin
            step();
            n++;
        end while ((busy || exp_id.size() != 0 || exp_fr.size() != 0) && n < budget);
        chk("idle", {29'd0, busy, exp_id.size() != 0, exp_fr.size() != 0}, 0);
    endtask

    initial begin
        int n;
        for (int i = 0; i < N; i++) begin
            head[i] = 0;
            tail[i] = 0;
        end
        repeat (3) @(negedge txclk);
        reset = 1'b0;
        for (int i = 0; i < 20; i++) begin
            step();
            chk("reset_state", {ack, grant_id, busy, err, ld_tx_data, tx_data, tx_enable}, 0);
        end
        // single byte, one-cycle latency, exact serial frame
        add(1, 8'hA5);
        expect_grant(1, 8'hA5, 1);
        step();
        chk("latency_ack", 32'(last_ack), 32'b0010);
        wait_idle(40);
        chk("line_idle", 32'(tx_out), 1);
        // all four requesting: round-robin from a fresh pointer
        reset = 1'b1;
        step();
        reset = 1'b0;
        for (int k = 0; k < 2; k++)
            for (int i = 0; i < N; i++) begin
                add(i, 8'(8'h30 + 16 * k + i));
                expect_grant(i, 8'(8'h30 + 16 * k + i), 1);
            end
        wait_idle(200);
        // uart busy: no ack while tx_empty low
        add(2, 8'h5A);
        expect_grant(2, 8'h5A, 0);
        stuck_full = 1'b1;
        for (int i = 0; i < 10; i++) begin
            step();
            chk("hold_while_full", {ack, busy}, 0);
        end
        stuck_full = 1'b0;
        stuck_empty = 1'b1;
        n = 0;
        do begin
            step();
            n++;
        end while (last_ack == '0 && n < 10);
        chk("timeout_ack", 32'(last_ack), 32'b0100);
        for (int k = 1; k <= 5; k++) begin
            step();
            chk("timeout_err", 32'(err), 32'(k == 5));
        end
        chk("timeout_state", {tx_enable, busy}, 0);
        stuck_empty = 1'b0;
        add(0, 8'h3C);
        expect_grant(0, 8'h3C, 1);
        wait_idle(40);
        // reset in the middle of a frame
        add(1, 8'hC3);
        expect_grant(1, 8'hC3, 0);
        n = 0;
        do begin
            step();
            n++;
        end while (u_cnt != 4'd5 && n < 40);
        chk("mid_frame_reached", 32'(u_cnt), 5);
        reset = 1'b1;
        step();
        chk("mid_frame_reset", {ack, busy, ld_tx_data, tx_enable}, 0);
        reset = 1'b0;
        step();
`ifdef UART_ARB_LOCK_EN
        add(1, 8'h11);
        expect_grant(1, 8'h11, 1);
        wait_idle(40);
        lock = 4'b0100;
        add(2, 8'h21);
        add(2, 8'h22);
        add(2, 8'h23);
        add(0, 8'h20);
        expect_grant(2, 8'h21, 1);
        expect_grant(2, 8'h22, 1);
        expect_grant(2, 8'h23, 1);
        expect_grant(0, 8'h20, 1);
        wait_idle(120);
        lock = '0;
`endif
        chk("err_pulses", err_seen, 1);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
